// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector controller: configurable pattern, overlap mode and
// window length, with a saturating hit counter and hit/done pulses.
module seq_detect_ctrl #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             busy,
    output logic             hit,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [PAT_W-1:0] pat_q;
    logic             ovl_q;
    logic [WIN_W-1:0] win_q;
    logic [PAT_W-1:0] sh_q, sh_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [WIN_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_q, done_q, busy_q;
    logic             match, last;

    assign cfg_ready = (state_q == IDLE) || (state_q == ARMED);
    assign busy      = busy_q;
    assign hit       = hit_q;
    assign done      = done_q;
    assign hit_cnt   = cnt_q;

    // Post-shift view of the datapath for the bit being accepted this edge
    always_comb begin
        sh_d   = {sh_q[PAT_W-2:0], bit_in};
        fill_d = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        bcnt_d = bcnt_q + 1'b1;
        cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        match  = (fill_d == FULL) && (sh_d == pat_q);
        last   = (win_q != '0) && (bcnt_d == win_q);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            win_q   <= '0;
            sh_q    <= '0;
            fill_q  <= '0;
            bcnt_q  <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, ARMED: begin
                    if (cfg_valid) begin
                        pat_q   <= cfg_pattern;
                        ovl_q   <= cfg_overlap;
                        win_q   <= cfg_window;
                        state_q <= ARMED;
                    end else if (state_q == ARMED && start) begin
                        sh_q    <= '0;
                        fill_q  <= '0;
                        bcnt_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= ARMED;
                    end else if (bit_valid) begin
                        sh_q   <= sh_d;
                        fill_q <= (match && !ovl_q) ? '0 : fill_d;
                        bcnt_q <= bcnt_d;
                        if (match) begin
                            hit_q <= 1'b1;
                            cnt_q <= cnt_d;
                        end
                        if (last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= ARMED;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: gating, overlap modes, window,
// saturation, abort and asynchronous reset.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       cfg_valid, cfg_ready;
    logic [4:0] cfg_pattern;
    logic       cfg_overlap;
    logic [15:0] cfg_window;
    logic       start, abort, bit_valid, bit_in;
    logic       busy, hit, done;
    logic [7:0] hit_cnt;

    int errs = 0;
    int checks = 0;

    logic [8:0] stream = 9'b011101110;

    seq_detect_ctrl dut (
        .clk(clk), .clr(clr),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
        .cfg_window(cfg_window),
        .start(start), .abort(abort),
        .bit_valid(bit_valid), .bit_in(bit_in),
        .busy(busy), .hit(hit), .done(done), .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [4:0] p, input logic o,
                       input logic [15:0] w);
        cfg_valid = 1'b1;
        cfg_pattern = p;
        cfg_overlap = o;
        cfg_window = w;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic b);
        bit_valid = 1'b1;
        bit_in = b;
        step();
        bit_valid = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    initial begin
        clr = 1'b0;
        cfg_valid = 0; cfg_pattern = '0; cfg_overlap = 0; cfg_window = '0;
        start = 0; abort = 0; bit_valid = 0; bit_in = 0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_hit", hit, 0);
        check("rst_done", done, 0);
        check("rst_cnt", hit_cnt, 0);
        check("rst_rdy", cfg_ready, 1);
        clr = 1'b1;
        step();

        // start in IDLE is ignored
        go();
        check("idle_start_busy", busy, 0);
        check("idle_start_rdy", cfg_ready, 1);

        // overlapping count
        cfg(5'b01110, 1'b1, 16'd0);
        check("armed_rdy", cfg_ready, 1);
        go();
        check("run_busy", busy, 1);
        check("run_cnt0", hit_cnt, 0);
        check("run_rdy", cfg_ready, 0);
        for (int i = 0; i < 9; i++) begin
            send(stream[8-i]);
            check($sformatf("ovl_hit%0d", i), hit, (i == 4 || i == 8));
        end
        check("ovl_cnt", hit_cnt, 2);
        check("ovl_nodone", done, 0);
        do_abort();
        check("ovl_abort_busy", busy, 0);
        check("ovl_abort_cnt", hit_cnt, 2);

        // non-overlapping count
        cfg(5'b01110, 1'b0, 16'd0);
        go();
        for (int i = 0; i < 9; i++) begin
            send(stream[8-i]);
            check($sformatf("novl_hit%0d", i), hit, (i == 4));
        end
        check("novl_cnt", hit_cnt, 1);
        do_abort();

        // window of 9 with random gaps
        cfg(5'b01110, 1'b1, 16'd9);
        go();
        for (int i = 0; i < 9; i++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
            send(stream[8-i]);
            check($sformatf("win_hit%0d", i), hit, (i == 4 || i == 8));
            check($sformatf("win_done%0d", i), done, (i == 8));
        end
        check("win_busy", busy, 0);
        check("win_rdy_done", cfg_ready, 0);
        check("win_cnt", hit_cnt, 2);
        step();
        check("win_done_pulse", done, 0);
        check("win_rdy_armed", cfg_ready, 1);
        check("win_cnt_hold", hit_cnt, 2);
        go();
        check("win_restart_busy", busy, 1);
        check("win_restart_cnt", hit_cnt, 0);
        do_abort();

        // saturation then abort with bit_valid
        cfg(5'b00000, 1'b1, 16'd0);
        go();
        for (int i = 0; i < 300; i++) send(1'b0);
        check("sat_cnt", hit_cnt, 255);
        check("sat_hit", hit, 1);
        abort = 1'b1;
        bit_valid = 1'b1;
        bit_in = 1'b0;
        step();
        abort = 1'b0;
        bit_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_hit", hit, 0);
        check("abort_done", done, 0);
        check("abort_cnt", hit_cnt, 255);
        check("abort_rdy", cfg_ready, 1);
        step();
        check("abort_nodone", done, 0);

        // asynchronous reset mid-run
        cfg(5'b01110, 1'b1, 16'd0);
        go();
        send(1'b0);
        send(1'b1);
        send(1'b1);
        check("mid_busy_pre", busy, 1);
        #3;
        clr = 1'b0;
        #1;
        check("clr_busy", busy, 0);
        check("clr_cnt", hit_cnt, 0);
        check("clr_rdy", cfg_ready, 1);
        check("clr_hit", hit, 0);
        #2;
        clr = 1'b1;
        step();
        go();
        check("clr_start_ignored", busy, 0);
        send(1'b1);
        send(1'b0);
        check("clr_bits_ignored", hit, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable serial-pattern detection controller for the sequence-detector datapath. It accepts a pattern, overlap mode and window length over a valid/ready configuration port, and arms on `start`. It then scans a qualified serial bit stream and counts pattern hits with a saturating counter. It reports per-hit pulses and a window-complete pulse to the surrounding control logic.

## Interface
- `PAT_W`, 5: pattern length in bits (2..8).
- `CNT_W`, 8: hit counter width.
- `WIN_W`, 16: window length counter width.
- `clk`  in  1  clock; all logic on rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `cfg_valid`  in  1  configuration request.
- `cfg_ready`  out  1  configuration accepted when high with `cfg_valid`.
- `cfg_pattern`  in  PAT_W  pattern; MSB is the first bit in time.
- `cfg_overlap`  in  1  1 = overlapping matches counted; 0 = non-overlapping.
- `cfg_window`  in  WIN_W  bits to scan per run; 0 = unlimited.
- `start`  in  1  begin a run (ARMED only).
- `abort`  in  1  terminate a run (RUN only).
- `bit_valid`  in  1  `bit_in` qualifier.
- `bit_in`  in  1  serial data bit.
- `busy`  out  1  high in RUN.
- `hit`  out  1  one-cycle pulse per match.
- `done`  out  1  one-cycle pulse at window completion.
- `hit_cnt`  out  CNT_W  hits in current/last run, saturating.

## Operation
- FSM states are IDLE, ARMED, RUN and DONE.
- Reset state is IDLE. `hit`, `done`, `busy` and `hit_cnt` are 0. The pattern, overlap and window registers are 0. The shift register, fill count and bit count are 0.
- `cfg_ready` = 1 in IDLE and ARMED, 0 in RUN and DONE (combinational from state).
- In IDLE or ARMED, `cfg_valid & cfg_ready` latches all three `cfg_*` fields and moves to ARMED. Reconfiguring in ARMED overwrites the previous values.
- In IDLE, `start` is ignored.
- In ARMED, `start` moves to RUN and clears `hit_cnt`, the shift register, fill and the bit count. If `cfg_valid` and `start` are both high in ARMED, the configuration is captured and `start` is ignored.
- In RUN, each edge with `bit_valid` = 1:
  - shift register becomes `{sh[PAT_W-2:0], bit_in}`;
  - fill increments, saturating at PAT_W;
  - bit count increments.
- A match is declared when the post-shift fill equals PAT_W and the post-shift register equals the pattern. On a match:
  - `hit` is set to 1 for one cycle;
  - `hit_cnt` increments, saturating at 2^CNT_W-1;
  - if `cfg_overlap` = 0, fill is reset to 0.
- In RUN, when window ≠ 0 and the accepted bit is the window-th bit, the FSM goes to DONE. A match on that same bit is counted normally.
- DONE asserts `done` for exactly one cycle, then returns to ARMED with the configuration retained. `hit_cnt` holds until the next `start`.
- In RUN, `abort` returns to ARMED, `done` is not asserted and `hit_cnt` is held. If `abort` and `bit_valid` are both high, `abort` wins and the bit is dropped.
- `bit_valid` is ignored outside RUN. `start` is ignored in RUN and DONE. `abort` is ignored outside RUN.

## Timing
- All outputs except `cfg_ready` are registered.
- `hit` is high in the cycle immediately after the edge that accepted the final pattern bit. `hit_cnt` reflects that hit in the same cycle, so bit-to-hit latency is 1 edge.
- Back-to-back `bit_valid` at full rate is supported. With overlap = 1, `hit` may stay high on consecutive cycles.
- `busy` rises on the edge after the `start` handshake. It falls on the edge that enters DONE or ARMED (abort).
- `done` is high in the cycle after the window-th bit's edge. `hit` may be high in the same cycle.
- `clr` low at any time (including mid-RUN) forces IDLE and all reset values immediately. The configuration is lost, and a new configuration is required before `start`.

## Test plan
- Configuration gating: `start` in IDLE -> `busy` stays 0. Then cfg pattern 5'b01110, overlap 1, window 0, then `start` -> `busy` = 1 one edge later, `hit_cnt` = 0.
- Overlapping count: pattern 01110, overlap 1, stream 0,1,1,1,0,1,1,1,0 at full rate -> `hit` pulses after bits 5 and 9, `hit_cnt` = 2.
- Non-overlapping count: the same stream with overlap 0 -> one `hit` after bit 5, `hit_cnt` = 1.
- Window and gaps: window 9, the same stream with random `bit_valid` gaps -> `hit` and `done` high in the same cycle after bit 9, `hit_cnt` = 2. The FSM returns to ARMED and `cfg_ready` = 1.
- Saturation and abort: pattern 5'b00000, overlap 1, 300 zeros -> `hit_cnt` saturates at 255. Then `abort` together with `bit_valid` -> ARMED, no `done`, `hit_cnt` = 255.
- Reset mid-run: `clr` low during RUN after 3 bits -> all outputs 0, IDLE, `cfg_ready` = 1. A subsequent `start` without configuration is ignored.
